// File: rtl/nn_intent_pkg.sv
// Shared definitions for the NN export word decoder: opcodes, field positions,
// FSM state encoding and the class-range helper.
package nn_intent_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int LOGIT_W_DEF     = 16;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOGIT  = 3'd2;
    localparam logic [2:0] OP_COMMIT = 3'd3;

    localparam int TOG_BIT  = 31;
    localparam int OP_HI    = 30;
    localparam int OP_LO    = 28;
    localparam int CLS_HI   = 27;
    localparam int CLS_LO   = 24;
    localparam int LOGIT_HI = 15;
    localparam int LOGIT_LO = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic logic class_ok(input logic [3:0] cls, input int num_classes);
        return (int'(cls) < num_classes);
    endfunction

endpackage

// File: rtl/nn_export_sync.sv
// Samples the PIO export word twice and flags a word once it is stable and
// carries a fresh toggle value, so each software write is taken exactly once.
module nn_export_sync
    import nn_intent_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    output logic        accept_pulse,
    output logic [31:0] word
);

    logic [31:0] s1_r;
    logic [31:0] s2_r;
    logic        last_tog_r;
    logic        accept_s;

    // Two-stage sample of the export word and toggle bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r       <= 32'd0;
            s2_r       <= 32'd0;
            last_tog_r <= 1'b0;
        end else begin
            s1_r <= data_in;
            s2_r <= s1_r;
            if (accept_s) begin
                last_tog_r <= s1_r[TOG_BIT];
            end
        end
    end

    // A word is taken only when both samples agree and the toggle has moved.
    always_comb begin
        if ((s1_r == s2_r) && (s1_r[TOG_BIT] != last_tog_r)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign accept_pulse = accept_s;
    assign word         = s2_r;

endmodule

// File: rtl/nn_intent_decoder.sv
// Decodes NN export words into a running argmax over class logits and
// publishes the winning class, score and batch size on COMMIT.
module nn_intent_decoder
    import nn_intent_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int LOGIT_W     = LOGIT_W_DEF
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [31:0]        nn_export_data,
    input  logic               err_clear,
    output logic               intent_valid,
    output logic [3:0]         intent_class,
    output logic [LOGIT_W-1:0] intent_score,
    output logic [4:0]         logit_count,
    output logic               busy,
    output logic               err_sticky
);

    logic               accept_s;
    logic [31:0]        word_s;
    logic [2:0]         op_s;
    logic [3:0]         cls_s;
    logic [LOGIT_W-1:0] logit_s;

    state_t             state_r, state_nxt_s;
    logic [LOGIT_W-1:0] run_max_r, run_max_nxt_s;
    logic [3:0]         run_cls_r, run_cls_nxt_s;
    logic [4:0]         run_cnt_r, run_cnt_nxt_s;
    logic               commit_s;
    logic               err_set_s;

    logic               valid_nxt_s;
    logic [3:0]         class_nxt_s;
    logic [LOGIT_W-1:0] score_nxt_s;
    logic [4:0]         count_nxt_s;
    logic               busy_nxt_s;
    logic               err_nxt_s;

    nn_export_sync u_sync (
        .clk          (clk_clk),
        .rst_n        (reset_reset_n),
        .data_in      (nn_export_data),
        .accept_pulse (accept_s),
        .word         (word_s)
    );

    assign op_s    = word_s[OP_HI:OP_LO];
    assign cls_s   = word_s[CLS_HI:CLS_LO];
    assign logit_s = word_s[LOGIT_HI:LOGIT_LO];

    // State and argmax accumulator registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r   <= IDLE;
            run_max_r <= '0;
            run_cls_r <= 4'd0;
            run_cnt_r <= 5'd0;
        end else begin
            state_r   <= state_nxt_s;
            run_max_r <= run_max_nxt_s;
            run_cls_r <= run_cls_nxt_s;
            run_cnt_r <= run_cnt_nxt_s;
        end
    end

    // Next-state and accumulator update for each accepted word.
    always_comb begin
        state_nxt_s   = state_r;
        run_max_nxt_s = run_max_r;
        run_cls_nxt_s = run_cls_r;
        run_cnt_nxt_s = run_cnt_r;
        commit_s      = 1'b0;
        err_set_s     = 1'b0;
        if (accept_s) begin
            case (op_s)
                OP_NOP: begin
                    state_nxt_s = state_r;
                end
                OP_CLEAR: begin
                    run_cnt_nxt_s = 5'd0;
                    state_nxt_s   = IDLE;
                end
                OP_LOGIT: begin
                    if (!class_ok(cls_s, NUM_CLASSES)) begin
                        err_set_s = 1'b1;
                    end else if (state_r == IDLE) begin
                        run_max_nxt_s = logit_s;
                        run_cls_nxt_s = cls_s;
                        run_cnt_nxt_s = 5'd1;
                        state_nxt_s   = ACCUM;
                    end else begin
                        // Strict compare: on a tie the earlier class stays.
                        if ($signed(logit_s) > $signed(run_max_r)) begin
                            run_max_nxt_s = logit_s;
                            run_cls_nxt_s = cls_s;
                        end else begin
                            run_max_nxt_s = run_max_r;
                        end
                        if (run_cnt_r != 5'd31) begin
                            run_cnt_nxt_s = run_cnt_r + 5'd1;
                        end else begin
                            run_cnt_nxt_s = run_cnt_r;
                        end
                    end
                end
                OP_COMMIT: begin
                    if (state_r == ACCUM) begin
                        commit_s      = 1'b1;
                        run_cnt_nxt_s = 5'd0;
                        state_nxt_s   = IDLE;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end
                default: begin
                    err_set_s = 1'b1;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of the published outputs; results hold between commits.
    always_comb begin
        valid_nxt_s = commit_s;
        class_nxt_s = intent_class;
        score_nxt_s = intent_score;
        count_nxt_s = logit_count;
        if (commit_s) begin
            class_nxt_s = run_cls_r;
            score_nxt_s = run_max_r;
            count_nxt_s = run_cnt_r;
        end else begin
            valid_nxt_s = 1'b0;
        end
        busy_nxt_s = (state_nxt_s == ACCUM);
        err_nxt_s  = err_set_s | (err_sticky & ~err_clear);
    end

    // Output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            intent_valid <= 1'b0;
            intent_class <= 4'd0;
            intent_score <= '0;
            logit_count  <= 5'd0;
            busy         <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            intent_valid <= valid_nxt_s;
            intent_class <= class_nxt_s;
            intent_score <= score_nxt_s;
            logit_count  <= count_nxt_s;
            busy         <= busy_nxt_s;
            err_sticky   <= err_nxt_s;
        end
    end

endmodule
